// File: rtl/seq_div_8by4.sv
// Purpose    : sequential restoring divider, unsigned DIVIDEND_W / DIVISOR_W -> quotient, remainder.
// Latency    : done pulses DIVIDEND_W cycles after the accept edge (1 cycle for a zero divisor).
// Backpressure: start is ignored while busy; no queuing, results hold until the next completion.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request, sampled only while idle
//   dividend, divisor   operands, captured on the accepting edge
//   busy                high while a division is in flight
//   done                one-cycle pulse when quotient/remainder/div_by_zero are updated
//   quotient, remainder registered results
//   div_by_zero         set when the accepted divisor was zero
module seq_div_8by4 #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZDIV = 2'd2
    } state_t;

    state_t state, state_nxt;

    // dvd_sr starts as the latched dividend; each iteration shifts its MSB out
    // into the partial remainder and shifts the new quotient bit in at the LSB,
    // so after DIVIDEND_W iterations it holds the complete quotient.
    logic [DIVIDEND_W-1:0] dvd_sr, dvd_sr_nxt;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVISOR_W-1:0]  part, part_nxt;
    logic [DIVISOR_W:0]    shifted;
    logic                  ge;
    logic [CNT_W-1:0]      cnt;
    logic                  last;

    // One restoring step. The stored partial remainder is always < divisor,
    // so after a successful subtract the result fits in DIVISOR_W bits and the
    // subtraction can be done on the low bits alone.
    always_comb begin
        shifted    = {part, dvd_sr[DIVIDEND_W-1]};
        ge         = (shifted >= {1'b0, dvs_q});
        part_nxt   = ge ? (shifted[DIVISOR_W-1:0] - dvs_q) : shifted[DIVISOR_W-1:0];
        dvd_sr_nxt = {dvd_sr[DIVIDEND_W-2:0], ge};
        last       = (cnt == CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? ZDIV : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            ZDIV:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_sr      <= '0;
            dvs_q       <= '0;
            part        <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_sr      <= dividend;
                        dvs_q       <= divisor;
                        part        <= '0;
                        cnt         <= CNT_W'(DIVIDEND_W);
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    dvd_sr <= dvd_sr_nxt;
                    part   <= part_nxt;
                    cnt    <= cnt - CNT_W'(1);
                    if (last) begin
                        quotient  <= dvd_sr_nxt;
                        remainder <= part_nxt;
                        done      <= 1'b1;
                    end
                end
                ZDIV: begin
                    quotient    <= '1;
                    remainder   <= '1;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_div_8by4.md
Name: seq_div_8by4

Overview:
- Sequential restoring divider for unsigned operands; 8-bit dividend by 4-bit divisor, producing quotient and remainder.
- Inverse of the team's 4x4 array multiplier. Sits beside it in the arithmetic tile, driven from the dedicated input pins via the top-level wrapper.
- One quotient bit per clock, with a start/busy/done handshake.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; also the iteration count.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when not busy.
- dividend  input  DIVIDEND_W  numerator; captured on the accepting edge.
- divisor  input  DIVISOR_W  denominator; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse: results valid.
- quotient  output  DIVIDEND_W  registered quotient.
- remainder  output  DIVISOR_W  registered remainder.
- div_by_zero  output  1  set when the accepted divisor was 0.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, div_by_zero, quotient and remainder all go to 0.
  - Holds until rst_n rises; the first edge after release behaves as IDLE.
- States are IDLE, RUN and ZDIV. done is registered and pulses in the cycle after the last working edge.
- IDLE:
  - If start=1, the edge is the accept edge (E0). Operands are latched, div_by_zero is cleared and the iteration count is set to DIVIDEND_W.
  - divisor==0 goes to ZDIV; otherwise goes to RUN. busy=1 after E0.
  - quotient and remainder are not cleared at E0. They hold the previous result until overwritten.
- RUN, restoring algorithm, one bit per edge:
  - Partial remainder is DIVISOR_W+1 bits wide.
  - Shift left, bringing in the next dividend MSB.
  - If partial >= divisor: subtract and shift 1 into the quotient; else shift 0.
- Edges E1..E8 perform the 8 iterations (DIVIDEND_W generally). At E8:
  - quotient and remainder are loaded.
  - done=1 for exactly one cycle; busy=0.
  - State returns to IDLE.
- Latency: done is high in the cycle following E(DIVIDEND_W), i.e. 8 cycles after the accept edge.
- ZDIV:
  - At E1: quotient = all ones (8'hFF), remainder = all ones (4'hF), div_by_zero=1.
  - done pulses for one cycle; busy=0; state returns to IDLE.
  - Latency is 1 cycle.
- start while busy=1 is ignored. No queuing, and in-flight operands are unaffected.
- start during the done cycle is accepted (state is IDLE), enabling back-to-back operation with no gap.
- Operand inputs may change freely after E0; only latched copies are used.
- Results and div_by_zero hold until the next completion or reset.
- Invariant for divisor != 0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Reset asserted mid-RUN aborts immediately. No done pulse; outputs return to 0.

Test Plan:
- dividend=100, divisor=7, start for 1 cycle -> busy high for 8 cycles; done pulse 8 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- dividend=255, divisor=1 -> quotient=255, remainder=0. Also dividend=13, divisor=15 -> quotient=0, remainder=13. Also dividend=0, divisor=5 -> quotient=0, remainder=0.
- dividend=200, divisor=0 -> done 1 cycle after accept; quotient=8'hFF, remainder=4'hF, div_by_zero=1. A subsequent valid start clears div_by_zero.
- Start 100/7, pulse start with 50/3 at cycle 3 of RUN -> second request ignored; result is 14 r 2; only one done pulse.
- Start 100/7, then start 50/3 held during the done cycle -> second accepted; 8 cycles later quotient=16, remainder=2.
- Start 255/1, assert rst_n=0 at cycle 4 -> busy, done and outputs go to 0 immediately. After release with start idle, no done ever pulses.
- Randomised sweep of all 8-bit/4-bit pairs, divisor != 0, against the invariant.
